permute_arbiter: RTL and testbench

Round-robin scheduler that shares one `permute` rotation datapath between `NREQ` requester threads. It accepts {hypervector, shift} requests over valid/ready and drives the datapath's `exec`/`data`/`permute_num` inputs. It tracks the datapath's one-cycle registered latency and returns each rotated vector, tagged with its requester id, over a backpressured response port. Sits between the per-thread encoder lanes and a single `permute` instance.

---
 rtl/permute_arbiter.sv | 164 ++++++++++++++++
 tb/tb_permute_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/permute_arbiter.sv
// permute_arbiter
//   Round-robin scheduler sharing one registered `permute` rotation datapath
//   between NREQ requester threads. Requests {vector, shift} arrive over
//   valid/ready, are issued to the datapath, and the rotated vector returns
//   one cycle later. It is then parked in a backpressured output register
//   tagged with the requester id.
//
// Parameters
//   DIM   MSB index of a hypervector (vectors are DIM+1 bits)
//   NREQ  number of requesters (>= 2)
//   IDW   requester id width
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (one-hot or zero)
//   req_data   packed request vectors, requester i at [i*(DIM+1) +: DIM+1]
//   req_num    packed shift amounts, requester i at [i*10 +: 10]
//   pu_exec    datapath execute strobe
//   pu_data    vector to the datapath
//   pu_num     shift to the datapath
//   pu_result  registered datapath result (holds when pu_exec=0)
//   rsp_valid  response valid
//   rsp_ready  response accept
//   rsp_id     requester index of the response
//   rsp_data   rotated vector
module permute_arbiter #(
  parameter int DIM  = 1023,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*(DIM+1)-1:0]  req_data,
  input  logic [NREQ*10-1:0]       req_num,
  output logic                     pu_exec,
  output logic [DIM:0]             pu_data,
  output logic [9:0]               pu_num,
  input  logic [DIM:0]             pu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [DIM:0]             rsp_data
);

  localparam int W = DIM + 1;

  logic            s1_vld;
  logic [IDW-1:0]  s1_id;
  logic [IDW-1:0]  rr_ptr;

  logic            out_free;
  logic            move;
  logic            can_issue;
  logic            grant;
  logic            found;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  ptr_next;
  logic [NREQ-1:0] mask_hi;
  logic [NREQ-1:0] valid_hi;

  // Pipeline advance: the in-flight result can move to the output register
  // whenever that register is empty or being drained this cycle.
  assign out_free  = !rsp_valid || rsp_ready;
  assign move      = s1_vld && out_free;
  assign can_issue = !s1_vld || move;

  // Round-robin search: prefer the lowest valid index at or above rr_ptr;
  // if none, wrap to the lowest valid index overall.
  always_comb begin
    mask_hi  = '0;
    for (int i = 0; i < NREQ; i++) begin
      mask_hi[i] = (IDW'(i) >= rr_ptr);
    end
    valid_hi = req_valid & mask_hi;
  end

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    if (|valid_hi) begin
      found = 1'b1;
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (valid_hi[i]) begin
          gnt_id = IDW'(i);
        end
      end
    end else if (|req_valid) begin
      found = 1'b1;
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          gnt_id = IDW'(i);
        end
      end
    end
  end

  // Gating with rst_n keeps every handshake output low while reset is held,
  // even though the underlying state is already zero.
  assign grant = found && can_issue && rst_n;

  assign ptr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (gnt_id == IDW'(i));
    end
  end

  // Datapath operands are forced to zero when idle so the datapath sees a
  // quiet bus rather than whichever requester the mux happens to select.
  always_comb begin
    pu_exec = grant;
    pu_data = '0;
    pu_num  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && (gnt_id == IDW'(i))) begin
        pu_data = req_data[i*W +: W];
        pu_num  = req_num[i*10 +: 10];
      end
    end
  end

  // Issue stage tracking. The datapath register itself holds the in-flight
  // vector; only its valid and owner are tracked here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_id  <= '0;
      rr_ptr <= '0;
    end else begin
      if (grant) begin
        s1_vld <= 1'b1;
        s1_id  <= gnt_id;
        rr_ptr <= ptr_next;
      end else if (move) begin
        s1_vld <= 1'b0;
      end
    end
  end

  // Output register. Data and id only load on move, so they stay stable
  // while a response is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (move) begin
        rsp_valid <= 1'b1;
        rsp_id    <= s1_id;
        rsp_data  <= pu_result;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_permute_arbiter.sv
// tb_permute_arbiter
//   Directed bench for permute_arbiter with DIM=31, NREQ=4. A small
//   registered rotate-right model stands in for the permute datapath.
module tb_permute_arbiter;

  localparam int DIM  = 31;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                    clk;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*(DIM+1)-1:0] req_data;
  logic [NREQ*10-1:0]      req_num;
  logic                    pu_exec;
  logic [DIM:0]            pu_data;
  logic [9:0]              pu_num;
  logic [DIM:0]            pu_result;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [DIM:0]            rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  // Expected rotated vectors per requester for the fixed request set:
  // r0: 0x1 >>> 1, r1: 0xA5 >>> 0, r2: 0x10 >>> 4, r3: 0x3 >>> 1
  logic [31:0] exp_rsp [4] = '{32'h8000_0000, 32'h0000_00A5, 32'h0000_0001, 32'h8000_0001};

  logic [3:0] fr_ready [6]  = '{4'b0100, 4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
  logic       fr_rv    [6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] fr_id    [6]  = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd0};

  logic [3:0] bp_ready [10] = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
  logic       bp_rv    [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] bp_id    [10] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};

  permute_arbiter #(.DIM(DIM), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_num   (req_num),
    .pu_exec   (pu_exec),
    .pu_data   (pu_data),
    .pu_num    (pu_num),
    .pu_result (pu_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] d, input logic [9:0] n);
    logic [63:0] dd;
    dd = {d, d} >> (n % 10'd32);
    return dd[31:0];
  endfunction

  // Datapath stand-in: registered, loads only on pu_exec, no reset.
  initial pu_result = '0;
  always @(posedge clk) begin
    if (pu_exec) pu_result <= rotr(pu_data, pu_num);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exec_cnt;

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    req_data  = {32'h0000_0003, 32'h0000_0010, 32'h0000_00A5, 32'h0000_0001};
    req_num   = {10'd1, 10'd4, 10'd0, 10'd1};

    // Reset state, with requests pending
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_pu_exec",   64'(pu_exec),   64'(0));
    chk("rst_pu_data",   64'(pu_data),   64'(0));
    chk("rst_pu_num",    64'(pu_num),    64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id",    64'(rsp_id),    64'(0));
    chk("rst_rsp_data",  64'(rsp_data),  64'(0));
    req_valid = 4'h0;
    #10;
    rst_n = 1'b1;
    tick();

    // All four requesters continuously valid for 6 cycles
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 6) ? 4'hF : 4'h0;
      #1;
      chk("rr_ready", 64'(req_ready), (c < 6) ? (64'(1) << (c % 4)) : 64'(0));
      chk("rr_rsp_valid", 64'(rsp_valid), (c >= 2 && c < 8) ? 64'(1) : 64'(0));
      if (c >= 2 && c < 8) begin
        chk("rr_rsp_id",   64'(rsp_id),   64'((c - 2) % 4));
        chk("rr_rsp_data", 64'(rsp_data), 64'(exp_rsp[(c - 2) % 4]));
      end
      tick();
    end

    // Fairness: req2 and req3 valid, pointer at 2
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 3) ? 4'b1100 : 4'b0000;
      #1;
      chk("fair_ready", 64'(req_ready), 64'(fr_ready[c]));
      chk("fair_rsp_valid", 64'(rsp_valid), 64'(fr_rv[c]));
      if (fr_rv[c]) begin
        chk("fair_rsp_id",   64'(rsp_id),   64'(fr_id[c]));
        chk("fair_rsp_data", 64'(rsp_data), 64'(exp_rsp[fr_id[c]]));
      end
      tick();
    end

    // Single request from req0: data=1, num=1
    req_valid = 4'b0001;
    #1;
    chk("s0_ready",   64'(req_ready), 64'(4'b0001));
    chk("s0_exec",    64'(pu_exec),   64'(1));
    chk("s0_pu_data", 64'(pu_data),   64'(32'h1));
    chk("s0_pu_num",  64'(pu_num),    64'(1));
    tick();
    req_valid = 4'b0000;
    #1;
    chk("s0_c1_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("s0_c1_exec",      64'(pu_exec),   64'(0));
    chk("s0_c1_pu_data",   64'(pu_data),   64'(0));
    tick();
    chk("s0_c2_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("s0_c2_rsp_id",    64'(rsp_id),    64'(0));
    chk("s0_c2_rsp_data",  64'(rsp_data),  64'(32'h8000_0000));
    tick();
    chk("s0_c3_rsp_valid", 64'(rsp_valid), 64'(0));

    // req1 alone, num=0, data=0xA5: identity rotation
    req_valid = 4'b0010;
    #1;
    chk("s1_ready",   64'(req_ready), 64'(4'b0010));
    chk("s1_pu_num",  64'(pu_num),    64'(0));
    chk("s1_pu_data", 64'(pu_data),   64'(32'hA5));
    tick();
    req_valid = 4'b0000;
    tick();
    chk("s1_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("s1_rsp_id",    64'(rsp_id),    64'(1));
    chk("s1_rsp_data",  64'(rsp_data),  64'(32'hA5));
    tick();
    chk("s1_c3_rsp_valid", 64'(rsp_valid), 64'(0));

    // Backpressure: all valid, rsp_ready low for 5 cycles
    exec_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 7) ? 4'hF : 4'h0;
      rsp_ready = (c < 5) ? 1'b0 : 1'b1;
      #1;
      if (c < 5 && pu_exec) exec_cnt++;
      chk("bp_ready", 64'(req_ready), 64'(bp_ready[c]));
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(bp_rv[c]));
      if (bp_rv[c]) begin
        chk("bp_rsp_id",   64'(rsp_id),   64'(bp_id[c]));
        chk("bp_rsp_data", 64'(rsp_data), 64'(exp_rsp[bp_id[c]]));
      end
      tick();
    end
    chk("bp_grant_count", 64'(exec_cnt), 64'(2));

    // Reset while a result is in flight and a response is pending
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("mr_c0_ready", 64'(req_ready), 64'(4'b0100));
    tick();
    chk("mr_c1_ready", 64'(req_ready), 64'(4'b1000));
    tick();
    chk("mr_pre_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("mr_pre_rsp_id",    64'(rsp_id),    64'(2));
    rst_n = 1'b0;
    #1;
    chk("mr_req_ready", 64'(req_ready), 64'(0));
    chk("mr_pu_exec",   64'(pu_exec),   64'(0));
    chk("mr_pu_data",   64'(pu_data),   64'(0));
    chk("mr_pu_num",    64'(pu_num),    64'(0));
    chk("mr_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mr_rsp_id",    64'(rsp_id),    64'(0));
    chk("mr_rsp_data",  64'(rsp_data),  64'(0));
    req_valid = 4'b0110;
    #1;
    rst_n = 1'b1;
    #1;
    chk("mr_first_ready", 64'(req_ready), 64'(4'b0010));
    chk("mr_first_data",  64'(pu_data),   64'(32'hA5));
    tick();
    req_valid = 4'b0000;
    #1;
    chk("mr_no_stale", 64'(rsp_valid), 64'(0));
    tick();
    chk("mr_rsp_valid_after", 64'(rsp_valid), 64'(1));
    chk("mr_rsp_id_after",    64'(rsp_id),    64'(1));
    chk("mr_rsp_data_after",  64'(rsp_data),  64'(32'hA5));
    tick();
    chk("mr_drained", 64'(rsp_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
